// File: rtl/draw_datapath.sv
// Consumer side of the drawing start/finished handshake: latches one packed instruction,
// then issues a single VGA pixel write (DRAW) or returns the next LFSR value (RAND).
module draw_datapath #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int OP_W     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int R_W      = 16
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              start,
  input  logic [OP_W+10+C_W+Y_W+X_W-1:0]    instruction,
  output logic                              finished,
  output logic [R_W-1:0]                    result,
  output logic                              error,
  output logic [X_W-1:0]                    vga_x,
  output logic [Y_W-1:0]                    vga_y,
  output logic [C_W-1:0]                    vga_colour,
  output logic                              vga_plot
);

  localparam int INSTR_W = OP_W + 10 + C_W + Y_W + X_W;
  localparam int Y_LSB   = X_W;
  localparam int C_LSB   = X_W + Y_W;
  localparam int PLOT_B  = X_W + Y_W + C_W;
  localparam int OP_LSB  = INSTR_W - OP_W;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_DRAW = OP_W'(1);
  localparam logic [OP_W-1:0] OP_RAND = OP_W'(2);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0] op_q;
  logic            plot_q;
  logic [C_W-1:0]  colour_q;
  logic [Y_W-1:0]  y_q;
  logic [X_W-1:0]  x_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_next;

  logic is_nop;
  logic is_draw;
  logic is_rand;
  logic is_illegal;
  logic in_range;
  logic draw_hit;

  // The pad field carries no meaning; fold it so it is visibly consumed.
  logic unused_pad;
  assign unused_pad = ^instruction[OP_LSB-1:PLOT_B+1];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE waits for start to fall so a held request is accepted exactly once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (!start) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign finished = (state_q == ST_IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      op_q     <= '0;
      plot_q   <= 1'b0;
      colour_q <= '0;
      y_q      <= '0;
      x_q      <= '0;
    end else if (state_q == ST_IDLE && start) begin
      op_q     <= instruction[INSTR_W-1:OP_LSB];
      plot_q   <= instruction[PLOT_B];
      colour_q <= instruction[PLOT_B-1:C_LSB];
      y_q      <= instruction[C_LSB-1:Y_LSB];
      x_q      <= instruction[X_W-1:0];
    end
  end

  assign is_nop     = (op_q == OP_NOP);
  assign is_draw    = (op_q == OP_DRAW);
  assign is_rand    = (op_q == OP_RAND);
  assign is_illegal = !(is_nop || is_draw || is_rand);

  // Widened compares stay correct even if a screen dimension equals 2**width.
  assign in_range = ({1'b0, x_q} < (X_W+1)'(SCREEN_W)) &&
                    ({1'b0, y_q} < (Y_W+1)'(SCREEN_H));
  assign draw_hit = is_draw && plot_q && in_range;

  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      result     <= '0;
      error      <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if (state_q == ST_EXEC) begin
        if (is_illegal) begin
          result <= {R_W{1'b1}};
          error  <= 1'b1;
        end else if (is_rand) begin
          result <= R_W'(lfsr_q);
          lfsr_q <= lfsr_next;
        end else if (draw_hit) begin
          result     <= '0;
          vga_x      <= x_q;
          vga_y      <= y_q;
          vga_colour <= colour_q;
          vga_plot   <= 1'b1;
        end else if (is_draw && plot_q) begin
          result <= R_W'(1);
        end else begin
          result <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_datapath.sv
// Randomised self-checking bench for draw_datapath: a transaction-level model predicts
// each instruction's outcome and a per-cycle compare process checks every output.
module tb_draw_datapath;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] instruction;
  logic        finished;
  logic [15:0] result;
  logic        error;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  draw_datapath dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .instruction(instruction),
    .finished   (finished),
    .result     (result),
    .error      (error),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clock = ~clock;

  int assertions = 0;
  int failures   = 0;
  bit check_en   = 1'b0;

  logic        exp_finished;
  logic [15:0] exp_result;
  logic        exp_error;
  logic        exp_plot;
  logic [7:0]  exp_x;
  logic [6:0]  exp_y;
  logic [2:0]  exp_colour;
  logic [15:0] model_lfsr;

  int          txn_plots;
  logic [15:0] obs_result;
  logic [7:0]  obs_x;
  logic [6:0]  obs_y;
  logic [2:0]  obs_colour;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every output is compared against the model on the falling edge of every cycle.
  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("finished",   32'(finished),   32'(exp_finished));
      checkOutput("result",     32'(result),     32'(exp_result));
      checkOutput("error",      32'(error),      32'(exp_error));
      checkOutput("vga_plot",   32'(vga_plot),   32'(exp_plot));
      checkOutput("vga_x",      32'(vga_x),      32'(exp_x));
      checkOutput("vga_y",      32'(vga_y),      32'(exp_y));
      checkOutput("vga_colour", 32'(vga_colour), 32'(exp_colour));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic plot,
                                     input logic [2:0] c, input logic [6:0] y,
                                     input logic [7:0] x);
    return {op, 9'd0, plot, c, y, x};
  endfunction

  task automatic modelReset();
    exp_finished = 1'b1;
    exp_result   = 16'h0000;
    exp_error    = 1'b0;
    exp_plot     = 1'b0;
    exp_x        = 8'd0;
    exp_y        = 7'd0;
    exp_colour   = 3'd0;
    model_lfsr   = 16'hACE1;
  endtask

  // Outcome of one instruction from the opcode rules, in plain integer arithmetic.
  task automatic modelExecute(input logic [31:0] w, output logic [15:0] res,
                              output logic plot, output logic illegal);
    int op;
    int x;
    int y;
    op      = int'(w[31:28]);
    x       = int'(w[7:0]);
    y       = int'(w[14:8]);
    plot    = 1'b0;
    illegal = 1'b0;
    res     = 16'h0000;
    if (op == 0) begin
      res = 16'h0000;
    end else if (op == 1) begin
      if (w[18] && x < 160 && y < 120) plot = 1'b1;
      else if (w[18]) res = 16'h0001;
    end else if (op == 2) begin
      res = model_lfsr;
      model_lfsr = (model_lfsr >> 1) ^ (((model_lfsr % 2) == 1) ? 16'hB400 : 16'h0000);
    end else begin
      res     = 16'hFFFF;
      illegal = 1'b1;
    end
  endtask

  // One handshake with start held high for 'hold' accepting edges.
  task automatic applyStimulus(input logic [31:0] w, input int hold);
    logic [15:0] p_res;
    logic        p_plot;
    logic        p_illegal;
    int          last;
    modelExecute(w, p_res, p_plot, p_illegal);
    last = (hold > 2) ? hold : 2;
    txn_plots = 0;
    start = 1'b1;
    instruction = w;
    for (int k = 0; k <= last; k++) begin
      step();
      if (vga_plot === 1'b1) begin
        txn_plots++;
        obs_x      = vga_x;
        obs_y      = vga_y;
        obs_colour = vga_colour;
      end
      if (k == 1) begin
        obs_result = result;
        exp_result = p_res;
        exp_plot   = p_plot;
        if (p_plot) begin
          exp_x      = w[7:0];
          exp_y      = w[14:8];
          exp_colour = w[17:15];
        end
        if (p_illegal) exp_error = 1'b1;
      end else begin
        exp_plot = 1'b0;
      end
      exp_finished = (k >= 2) && (k >= hold);
      start = (k + 1 < hold);
      instruction = $urandom();
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      instruction = $urandom();
      step();
    end
  endtask

  task automatic resetDut();
    resetn = 1'b0;
    start  = 1'b0;
    step();
    modelReset();
    check_en = 1'b1;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  op;
    int          r;
    int          raster_plots;

    resetn = 1'b0;
    start = 1'b0;
    instruction = 32'h0;
    resetDut();
    checkOutput("reset_finished", 32'(finished), 32'h1);
    checkOutput("reset_result",   32'(result),   32'h0);
    checkOutput("reset_error",    32'(error),    32'h0);
    checkOutput("reset_plot",     32'(vga_plot), 32'h0);

    applyStimulus(mk(4'd2, 1'b0, 3'd0, 7'd0, 8'd0), 1);
    checkOutput("rand_first", 32'(obs_result), 32'hACE1);
    applyStimulus(mk(4'd2, 1'b0, 3'd0, 7'd0, 8'd0), 2);
    checkOutput("rand_second", 32'(obs_result), 32'hE270);

    applyStimulus(mk(4'd1, 1'b1, 3'b111, 7'd5, 8'd10), 2);
    checkOutput("draw_pulses", 32'(txn_plots),  32'd1);
    checkOutput("draw_x",      32'(obs_x),      32'd10);
    checkOutput("draw_y",      32'(obs_y),      32'd5);
    checkOutput("draw_colour", 32'(obs_colour), 32'd7);
    checkOutput("draw_result", 32'(obs_result), 32'h0);

    applyStimulus(mk(4'd1, 1'b1, 3'd2, 7'd0, 8'd160), 1);
    checkOutput("clip_pulses", 32'(txn_plots),  32'd0);
    checkOutput("clip_result", 32'(obs_result), 32'h0001);
    applyStimulus(mk(4'd1, 1'b0, 3'd2, 7'd0, 8'd160), 1);
    checkOutput("noplot_pulses", 32'(txn_plots),  32'd0);
    checkOutput("noplot_result", 32'(obs_result), 32'h0000);

    applyStimulus(mk(4'd1, 1'b1, 3'd4, 7'd119, 8'd159), 6);
    checkOutput("held_start_pulses", 32'(txn_plots), 32'd1);

    applyStimulus(mk(4'hF, 1'b1, 3'd1, 7'd1, 8'd1), 1);
    checkOutput("illegal_result", 32'(obs_result), 32'hFFFF);
    checkOutput("illegal_error",  32'(error),      32'h1);
    checkOutput("illegal_pulses", 32'(txn_plots),  32'd0);
    applyStimulus(mk(4'd0, 1'b0, 3'd0, 7'd0, 8'd0), 1);
    checkOutput("error_sticky", 32'(error), 32'h1);
    applyStimulus(mk(4'd2, 1'b0, 3'd0, 7'd0, 8'd0), 1);
    checkOutput("rand_after_illegal", 32'(obs_result), 32'h7138);
    resetDut();
    checkOutput("error_cleared", 32'(error), 32'h0);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) resetDut();
      r = int'($urandom_range(0, 99));
      if (r < 55)      op = 4'd1;
      else if (r < 75) op = 4'd2;
      else if (r < 90) op = 4'd0;
      else             op = 4'($urandom_range(3, 15));
      w = $urandom();
      w[31:28] = op;
      w[7:0]   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(150, 170));
      w[14:8]  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127))
                                             : 7'($urandom_range(110, 127));
      applyStimulus(w, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 3)));
    end

    // Reset landing on the EXEC edge of a valid DRAW must drop the write.
    resetDut();
    start = 1'b1;
    instruction = mk(4'd1, 1'b1, 3'd5, 7'd20, 8'd20);
    step();
    exp_finished = 1'b0;
    start = 1'b0;
    resetn = 1'b0;
    step();
    modelReset();
    checkOutput("reset_in_exec_plot", 32'(vga_plot), 32'h0);
    resetn = 1'b1;
    idleCycles(2);

    raster_plots = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        applyStimulus(mk(4'd1, 1'b1, 3'(x + y), 7'(y), 8'(x)), 1);
        raster_plots += txn_plots;
      end
    end
    checkOutput("raster_pulses",   32'(raster_plots), 32'd19200);
    checkOutput("raster_last_x",   32'(obs_x),        32'd159);
    checkOutput("raster_last_y",   32'(obs_y),        32'd119);
    checkOutput("raster_finished", 32'(finished),     32'h1);

    idleCycles(2);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
